// File: rtl/niosii_onchip_mem_loader.sv
// Byte-stream loader for the Nios II on-chip RAM: packs bytes little-endian into
// 32-bit words, writes them from a base word address, sums them, and optionally reads back.
module niosii_onchip_mem_loader #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 6250,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              verify,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              mem_clken
);
    localparam int WW = CNT_W + 1;
    localparam int SW = CNT_W + 2;

    typedef enum logic [2:0] {IDLE, CHECK, FILL, WRITE, VRD, VEND, DONE} state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  byte_idx_r;
    logic              verify_r;
    logic [WW-1:0]     words_r;
    logic [WW-1:0]     word_idx_r;
    logic [WW-1:0]     rd_idx_r;
    logic [31:0]       wbuf_r;
    logic [3:0]        wbe_r;
    logic [31:0]       vsum_r;
    logic              rd_pend_r;
    logic [31:0]       rd_mask_r;

    logic [WW-1:0]     words_s;
    logic              range_err_s;
    logic [1:0]        lane_s;
    logic [31:0]       buf_next_s;
    logic [3:0]        be_next_s;
    logic              last_byte_s;
    logic [31:0]       tail_mask_s;
    logic [31:0]       cur_mask_s;
    logic [31:0]       vsum_next_s;
    logic [ADDR_W-1:0] wr_addr_s;

    // Word packing, range test and read-back masking helpers
    always_comb begin
        words_s     = (WW'(count_r) + WW'(3)) >> 2;
        range_err_s = (SW'(base_r) + SW'(words_s)) > SW'(DEPTH);
        lane_s      = byte_idx_r[1:0];
        buf_next_s  = wbuf_r | ({24'd0, in_data} << {lane_s, 3'b000});
        be_next_s   = wbe_r | (4'b0001 << lane_s);
        last_byte_s = (byte_idx_r == (count_r - CNT_W'(1)));
        wr_addr_s   = base_r + ADDR_W'(word_idx_r);
        case (count_r[1:0])
            2'd1:    tail_mask_s = 32'h0000_00FF;
            2'd2:    tail_mask_s = 32'h0000_FFFF;
            2'd3:    tail_mask_s = 32'h00FF_FFFF;
            default: tail_mask_s = 32'hFFFF_FFFF;
        endcase
        if (rd_idx_r == (words_r - WW'(1))) begin
            cur_mask_s = tail_mask_s;
        end else begin
            cur_mask_s = 32'hFFFF_FFFF;
        end
        if (rd_pend_r) begin
            vsum_next_s = vsum_r + (mem_readdata & rd_mask_r);
        end else begin
            vsum_next_s = vsum_r;
        end
    end

    // Command FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            base_r         <= '0;
            count_r        <= '0;
            byte_idx_r     <= '0;
            verify_r       <= 1'b0;
            words_r        <= '0;
            word_idx_r     <= '0;
            rd_idx_r       <= '0;
            wbuf_r         <= 32'd0;
            wbe_r          <= 4'd0;
            vsum_r         <= 32'd0;
            rd_pend_r      <= 1'b0;
            rd_mask_r      <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            checksum       <= 32'd0;
            in_ready       <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= 4'd0;
            mem_writedata  <= 32'd0;
            mem_clken      <= 1'b1;
        end else begin
            mem_clken <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        base_r     <= base_addr;
                        count_r    <= byte_count;
                        verify_r   <= verify;
                        error      <= 1'b0;
                        checksum   <= 32'd0;
                        vsum_r     <= 32'd0;
                        byte_idx_r <= '0;
                        word_idx_r <= '0;
                        wbuf_r     <= 32'd0;
                        wbe_r      <= 4'd0;
                        busy       <= 1'b1;
                        state_r    <= CHECK;
                    end
                end
                CHECK: begin
                    words_r <= words_s;
                    if (range_err_s) begin
                        error   <= 1'b1;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else if (count_r == CNT_W'(0)) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state_r  <= FILL;
                    end
                end
                FILL: begin
                    if (in_valid && in_ready) begin
                        byte_idx_r <= byte_idx_r + CNT_W'(1);
                        if (lane_s == 2'd3 || last_byte_s) begin
                            in_ready       <= 1'b0;
                            mem_chipselect <= 1'b1;
                            mem_write      <= 1'b1;
                            mem_address    <= wr_addr_s;
                            mem_byteenable <= be_next_s;
                            mem_writedata  <= buf_next_s;
                            wbuf_r         <= 32'd0;
                            wbe_r          <= 4'd0;
                            state_r        <= WRITE;
                        end else begin
                            wbuf_r <= buf_next_s;
                            wbe_r  <= be_next_s;
                        end
                    end
                end
                WRITE: begin
                    checksum       <= checksum + mem_writedata;
                    word_idx_r     <= word_idx_r + WW'(1);
                    mem_write      <= 1'b0;
                    mem_byteenable <= 4'd0;
                    mem_writedata  <= 32'd0;
                    if (byte_idx_r != count_r) begin
                        mem_chipselect <= 1'b0;
                        in_ready       <= 1'b1;
                        state_r        <= FILL;
                    end else if (verify_r) begin
                        mem_chipselect <= 1'b1;
                        mem_address    <= base_r;
                        rd_idx_r       <= '0;
                        rd_pend_r      <= 1'b0;
                        state_r        <= VRD;
                    end else begin
                        mem_chipselect <= 1'b0;
                        done           <= 1'b1;
                        state_r        <= DONE;
                    end
                end
                VRD: begin
                    // Data for the address presented last cycle arrives now
                    vsum_r    <= vsum_next_s;
                    rd_pend_r <= 1'b1;
                    rd_mask_r <= cur_mask_s;
                    if (rd_idx_r == (words_r - WW'(1))) begin
                        mem_chipselect <= 1'b0;
                        state_r        <= VEND;
                    end else begin
                        rd_idx_r    <= rd_idx_r + WW'(1);
                        mem_address <= base_r + ADDR_W'(rd_idx_r + WW'(1));
                    end
                end
                VEND: begin
                    rd_pend_r <= 1'b0;
                    vsum_r    <= vsum_next_s;
                    error     <= (vsum_next_s != checksum);
                    done      <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r        <= IDLE;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                    in_ready       <= 1'b0;
                    mem_chipselect <= 1'b0;
                    mem_write      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_niosii_onchip_mem_loader.sv
// Directed bench for niosii_onchip_mem_loader with a behavioural single-port RAM
// (read latency 1) that logs every write and read.
module tb_niosii_onchip_mem_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] base_addr = 13'd0;
    logic [15:0] byte_count = 16'd0;
    logic        verify = 1'b0;
    logic        busy, done, error;
    logic [31:0] checksum;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'd0;

    niosii_onchip_mem_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .byte_count(byte_count), .verify(verify), .busy(busy), .done(done),
        .error(error), .checksum(checksum), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_clken(mem_clken)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:8191];
    logic [31:0] flip = 32'd0;
    int          cyc_cnt = 0;
    int          nw = 0;
    int          nr = 0;
    logic [31:0] wa [0:63];
    logic [31:0] wd [0:63];
    logic [31:0] wb [0:63];
    logic [31:0] ra [0:63];
    int          rc [0:63];

    // RAM model plus write/read logging
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_chipselect && mem_write) begin
            for (int i = 0; i < 4; i++)
                if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            wa[nw[5:0]] <= 32'(mem_address);
            wd[nw[5:0]] <= mem_writedata;
            wb[nw[5:0]] <= 32'(mem_byteenable);
            nw <= nw + 1;
        end else if (mem_chipselect) begin
            mem_readdata <= ram[mem_address] ^ flip;
            ra[nr[5:0]] <= 32'(mem_address);
            rc[nr[5:0]] <= cyc_cnt;
            nr <= nr + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0]  bytes [0:15];
    logic        got_done;
    int          done_cyc;
    logic [31:0] res_sum;
    logic        res_err;

    task automatic outs_at_reset(input string tag);
        chk({tag, "_ctl"}, 32'({busy, done, error, in_ready, mem_chipselect, mem_write, mem_clken}),
            32'h0000_0001);
        chk({tag, "_sum"}, checksum, 32'd0);
        chk({tag, "_mem"}, {mem_address, 15'd0, mem_byteenable}, 32'd0);
        chk({tag, "_wdata"}, mem_writedata, 32'd0);
    endtask

    task automatic do_cmd(input logic [12:0] b, input logic [15:0] c, input logic v,
                          input logic gaps, input int abort_at);
        int  k;
        int  cyc;
        logic acc;
        k = 0;
        cyc = 0;
        got_done = 1'b0;
        done_cyc = -1;
        @(negedge clk);
        base_addr = b; byte_count = c; verify = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < 2000) begin
            if (abort_at > 0 && k == abort_at) begin
                reset_n = 1'b0;
                #1;
                outs_at_reset("abort");
                break;
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                res_sum  = checksum;
                res_err  = error;
            end
            if (k < int'(c) && !(gaps && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b1;
                in_data  = bytes[k];
            end else begin
                in_valid = 1'b0;
            end
            if (gaps && !got_done && (cyc % 5) == 2) begin
                start = 1'b1; base_addr = 13'h300; byte_count = 16'd4;
            end else begin
                start = 1'b0;
            end
            acc = in_valid & in_ready;
            @(posedge clk);
            if (acc) k++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (abort_at == 0) begin
            chk("done_seen", 32'(got_done), 32'd1);
            chk("busy_fall", 32'(busy), 32'd0);
        end
    endtask

    int w0;
    int r0;

    initial begin
        repeat (3) @(negedge clk);
        outs_at_reset("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Two full words
        for (int i = 0; i < 8; i++) bytes[i] = 8'(i + 1);
        w0 = nw;
        do_cmd(13'h010, 16'd8, 1'b0, 1'b0, 0);
        chk("t1_nw", 32'(nw - w0), 32'd2);
        chk("t1_a0", wa[w0], 32'h010);
        chk("t1_d0", wd[w0], 32'h0403_0201);
        chk("t1_b0", wb[w0], 32'hF);
        chk("t1_a1", wa[w0+1], 32'h011);
        chk("t1_d1", wd[w0+1], 32'h0807_0605);
        chk("t1_b1", wb[w0+1], 32'hF);
        chk("t1_sum", res_sum, 32'h0C0A_0806);
        chk("t1_err", 32'(res_err), 32'd0);

        // Partial tail word
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
        bytes[3] = 8'hDD; bytes[4] = 8'hEE; bytes[5] = 8'hFF;
        w0 = nw;
        do_cmd(13'h000, 16'd6, 1'b0, 1'b0, 0);
        chk("t2_nw", 32'(nw - w0), 32'd2);
        chk("t2_d0", wd[w0], 32'hDDCC_BBAA);
        chk("t2_a1", wa[w0+1], 32'h001);
        chk("t2_d1", wd[w0+1], 32'h0000_FFEE);
        chk("t2_b1", wb[w0+1], 32'h3);
        chk("t2_sum", res_sum, 32'hDDCD_BB98);

        // Range error at the top of RAM, no memory access
        w0 = nw; r0 = nr;
        do_cmd(13'd6249, 16'd8, 1'b0, 1'b0, 0);
        chk("t3_nacc", 32'((nw - w0) + (nr - r0)), 32'd0);
        chk("t3_lat", 32'(done_cyc), 32'd1);
        chk("t3_err", 32'(res_err), 32'd1);

        // Last legal placement
        w0 = nw;
        do_cmd(13'd6248, 16'd8, 1'b0, 1'b0, 0);
        chk("t4_nw", 32'(nw - w0), 32'd2);
        chk("t4_a1", wa[w0+1], 32'd6249);
        chk("t4_err", 32'(res_err), 32'd0);

        // Zero-length command
        w0 = nw;
        do_cmd(13'h020, 16'd0, 1'b0, 1'b0, 0);
        chk("t5_nw", 32'(nw - w0), 32'd0);
        chk("t5_lat", 32'(done_cyc), 32'd1);
        chk("t5_sum", 32'(res_sum), 32'd0);
        chk("t5_err", 32'(res_err), 32'd0);

        // Verify pass, clean and with a corrupted read
        for (int i = 0; i < 12; i++) bytes[i] = 8'(8'h10 + i);
        r0 = nr;
        do_cmd(13'h100, 16'd12, 1'b1, 1'b0, 0);
        chk("t6_nr", 32'(nr - r0), 32'd3);
        chk("t6_ra0", ra[r0], 32'h100);
        chk("t6_ra2", ra[r0+2], 32'h102);
        chk("t6_gap1", 32'(rc[r0+1] - rc[r0]), 32'd1);
        chk("t6_gap2", 32'(rc[r0+2] - rc[r0+1]), 32'd1);
        chk("t6_sum", res_sum, 32'h4542_3F3C);
        chk("t6_err", 32'(res_err), 32'd0);
        flip = 32'h0000_0100;
        do_cmd(13'h100, 16'd12, 1'b1, 1'b0, 0);
        chk("t6f_err", 32'(res_err), 32'd1);
        flip = 32'd0;

        // Verify of a tail word whose unwritten lanes hold stale data
        for (int i = 0; i < 8; i++) bytes[i] = 8'hFF;
        do_cmd(13'h200, 16'd8, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) bytes[i] = 8'(i + 1);
        do_cmd(13'h200, 16'd6, 1'b1, 1'b0, 0);
        chk("t7_sum", res_sum, 32'h0403_0806);
        chk("t7_err", 32'(res_err), 32'd0);

        // Stream gaps and stray starts while busy
        for (int i = 0; i < 8; i++) bytes[i] = 8'(i + 1);
        w0 = nw;
        do_cmd(13'h020, 16'd8, 1'b0, 1'b1, 0);
        chk("t8_nw", 32'(nw - w0), 32'd2);
        chk("t8_a0", wa[w0], 32'h020);
        chk("t8_d0", wd[w0], 32'h0403_0201);
        chk("t8_d1", wd[w0+1], 32'h0807_0605);
        chk("t8_sum", res_sum, 32'h0C0A_0806);

        // Reset mid-load, then a clean run
        for (int i = 0; i < 12; i++) bytes[i] = 8'(8'h50 + i);
        do_cmd(13'h040, 16'd12, 1'b0, 1'b0, 5);
        @(negedge clk);
        reset_n = 1'b1;
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
        bytes[3] = 8'hDD; bytes[4] = 8'hEE; bytes[5] = 8'hFF;
        w0 = nw;
        do_cmd(13'h050, 16'd6, 1'b0, 1'b0, 0);
        chk("t9_nw", 32'(nw - w0), 32'd2);
        chk("t9_a0", wa[w0], 32'h050);
        chk("t9_sum", res_sum, 32'hDDCD_BB98);
        chk("t9_err", 32'(res_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/niosii_onchip_mem_loader.md
# niosii_onchip_mem_loader

Avalon-MM write master that sits directly upstream of the Nios II on-chip program/data RAM (32-bit, 13-bit word address, 6250 words, single port, read latency 1, no waitrequest). It takes a byte stream (UART/JTAG boot path), packs bytes little-endian into 32-bit words, writes them to a software-given base word address with correct byteenables for a partial tail, and keeps a running checksum. An optional verify pass reads the region back and flags any mismatch.

## Interface
- ADDR_W, 13, word-address width of the target RAM
- DEPTH, 6250, number of 32-bit words in the target RAM
- CNT_W, 16, width of byte_count

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle command strobe, honoured only when idle
- base_addr  in  ADDR_W  first word address, sampled on accepted start
- byte_count  in  CNT_W  bytes to load, sampled on accepted start
- verify  in  1  sampled on accepted start; 1 = read-back pass after load
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- error  out  1  range or verify failure; valid with done, held until next accepted start
- checksum  out  32  sum mod 2^32 of written words (unwritten lanes as 0); valid with done, held until next accepted start
- in_data  in  8  stream byte
- in_valid  in  1  stream byte valid
- in_ready  out  1  loader accepts byte when in_valid & in_ready
- mem_address  out  ADDR_W  RAM word address
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_byteenable  out  4  lane enables, bit n = writedata[8n+7:8n]
- mem_writedata  out  32  write data
- mem_readdata  in  32  RAM read data, valid one cycle after address presented with chipselect & ~write
- mem_clken  out  1  RAM clock enable, constant 1 out of reset

## Operation
- States: IDLE, CHECK, FILL, WRITE, VRD, VEND, DONE.
- IDLE: in_ready=0, mem_chipselect=0. start → latch base_addr, byte_count, verify; clear error, checksum, lane index; go CHECK. start outside IDLE ignored.
- CHECK (1 cycle): words = ceil(byte_count/4), computed at CNT_W+1 bits. If base_addr + words > DEPTH → error=1, go DONE, no memory access. If byte_count==0 → DONE, checksum 0, error 0. Else → FILL.
- FILL: in_ready=1. Accepted byte k of the command goes to lane k%4 of the word buffer, lane enable set. After lane 3 is filled or the final byte is accepted → WRITE.
- WRITE (1 cycle): mem_chipselect=1, mem_write=1, address=base+word index, byteenable=filled lanes (0xF, or 0x1/0x3/0x7 on tail), writedata=buffer with unfilled lanes 0. checksum += writedata. Clear buffer/enables; word index+1. More bytes remain → FILL; else verify ? VRD : DONE.
- VRD: one read per cycle, mem_chipselect=1, mem_write=0, addresses base..base+words-1. Each returned word (one cycle later) is masked with that word's byteenable pattern and summed into a separate verify sum. After last address issued → VEND.
- VEND (1 cycle): captures last read data; verify sum != checksum → error=1. → DONE.
- DONE (1 cycle): done=1, busy=1 → IDLE.
- Address arithmetic never wraps; CHECK guarantees last address ≤ DEPTH-1.

## Timing
- Reset values: busy 0, done 0, error 0, checksum 0, in_ready 0, mem_chipselect 0, mem_write 0, mem_address 0, mem_byteenable 0, mem_writedata 0; mem_clken 1. State IDLE.
- busy rises the cycle after accepted start, falls the cycle after done.
- Byte throughput: full word = 4 accept cycles + 1 WRITE cycle (in_ready=0 in WRITE). in_valid gaps simply stall FILL.
- Minimum latency start→done: zero-length or range error = 2 cycles later (CHECK, DONE).
- Verify of N words: N VRD cycles + 1 VEND + DONE.
- reset_n low mid-operation: immediate return to reset values; RAM contents already written stay; no done pulse.
- All outputs registered.

## Test plan
- base 0x010, count 8, bytes 01..08, verify 0 → writes 0x010 data 0x04030201 BE 0xF, 0x011 data 0x08070605 BE 0xF; checksum 0x0C0A0806; done, error 0.
- base 0x000, count 6, bytes AA BB CC DD EE FF → second write addr 0x001 data 0x0000FFEE BE 0x3; checksum 0xDDCDBB98.
- base 6249, count 8 → no mem_write ever, done 2 cycles after start, error 1; base 6248 count 8 → 2 writes, error 0.
- Load 12 bytes with verify 1, model returns correct data → 3 reads at consecutive cycles, error 0; repeat with one readdata bit flipped → error 1.
- Random in_valid gaps and start pulses while busy → identical writes/checksum as gap-free run; extra starts ignored.
- Assert reset_n low after 5 bytes accepted → all outputs at reset values same cycle; next start runs cleanly from IDLE.
